// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue between a
// synchronous-read instruction memory and the IF/ID boundary.
module if_prefetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freeze,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_address,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [DATA_W-1:0]           imem_rdata,
    output logic [ADDR_W-1:0]           PC,
    output logic [DATA_W-1:0]           Instruction,
    output logic                        valid,
    output logic [$clog2(DEPTH):0]      fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_issued_addr;
    logic              r_inflight;
    logic              r_kill;

    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
    logic [DATA_W-1:0] r_fifo_instr [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_occupancy;
    logic [CNT_W:0]    w_limit;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && !freeze && !branch_taken;
    assign w_push  = r_inflight && !r_kill && !branch_taken;

    // The in-flight request is counted as occupied so its response always has room.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_limit     = (CNT_W + 1)'(DEPTH) + {{CNT_W{1'b0}}, w_pop};
    assign w_issue     = !rst && !branch_taken && (w_occupancy < w_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_issued_addr <= RESET_PC;
            r_inflight    <= 1'b0;
            r_kill        <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= branch_taken;
            if (w_issue) begin
                r_issued_addr <= r_fetch_pc;
            end

            if (branch_taken) begin
                r_fetch_pc <= branch_address;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end

            if (branch_taken) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_issued_addr + ADDR_W'(4);
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign valid       = w_valid;
    assign PC          = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign Instruction = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign fifo_count  = r_count;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a memory returning its own address,
// a scoreboard of expected fetch addresses and popped entries, and targeted checks.
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        valid;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_fetch [$];
    logic [31:0] exp_pc    [$];
    logic [31:0] exp_ins   [$];

    if_prefetch_stage #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .PC(PC), .Instruction(Instruction), .valid(valid), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory whose word at each address equals the address.
    always @(posedge clk) imem_rdata <= imem_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic underflow(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=empty-queue expected=entry", tag);
    endtask

    // After a redirect or reset the fetch stream is sequential from the new start.
    task automatic refill(input logic [31:0] start);
        logic [31:0] a;
        exp_fetch.delete();
        exp_pc.delete();
        exp_ins.delete();
        for (int i = 0; i < 64; i++) begin
            a = start + 32'(4 * i);
            exp_fetch.push_back(a);
            exp_pc.push_back(a + 32'd4);
            exp_ins.push_back(a);
        end
    endtask

    task automatic cyc();
        #1;
        if (rst) begin
            refill(32'h0);
        end else begin
            if (branch_taken) chk("req_in_branch", {63'd0, imem_req}, 64'd0);
            if (imem_req) begin
                if (exp_fetch.size() == 0) underflow("fetch_queue");
                else chk("imem_addr", {32'd0, imem_addr}, {32'd0, exp_fetch.pop_front()});
            end
            if (!valid) chk("instr_idle", {32'd0, Instruction}, 64'd0);
            if (fifo_count > 3'd4) chk("count_bound", {61'd0, fifo_count}, 64'd4);
            if (valid && !freeze && !branch_taken) begin
                if (exp_pc.size() == 0) underflow("pop_queue");
                else begin
                    chk("pop_pc", {32'd0, PC}, {32'd0, exp_pc.pop_front()});
                    chk("pop_instr", {32'd0, Instruction}, {32'd0, exp_ins.pop_front()});
                end
            end
            if (branch_taken) refill(branch_address);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 8) begin
            cyc();
            n++;
        end
        if (!valid) begin
            total++;
            bad++;
            $error("FAIL %s observed=timeout expected=valid", tag);
        end
    endtask

    initial begin
        // Reset and reset values
        repeat (3) cyc();
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_pc", {32'd0, PC}, 64'd0);
        chk("rst_instr", {32'd0, Instruction}, 64'd0);
        chk("rst_count", {61'd0, fifo_count}, 64'd0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", {32'd0, imem_addr}, 64'd0);

        // Reset then run: first request at RESET_PC, then one entry per cycle
        rst = 1'b0;
        #1;
        chk("c0_req", {63'd0, imem_req}, 64'd1);
        chk("c0_valid", {63'd0, valid}, 64'd0);
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("run_valid", {63'd0, valid}, 64'd1);
            chk("run_pc", {32'd0, PC}, 64'(32'd4 + 32'(4 * k)));
            chk("run_instr", {32'd0, Instruction}, 64'(32'(4 * k)));
            cyc();
        end

        // Freeze fill: freeze applied once PC=4 has been consumed
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        freeze = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("frz_head_pc", {32'd0, PC}, 64'h8);
            cyc();
        end
        chk("frz_count", {61'd0, fifo_count}, 64'd4);
        chk("frz_req", {63'd0, imem_req}, 64'd0);
        freeze = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("rel_valid", {63'd0, valid}, 64'd1);
            chk("rel_pc", {32'd0, PC}, 64'(32'd8 + 32'(4 * k)));
            cyc();
        end

        // Branch flush with a non-empty queue
        chk("pre_br_valid", {63'd0, valid}, 64'd1);
        branch_taken = 1'b1;
        branch_address = 32'h100;
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("br_bubble", {63'd0, valid}, 64'd0);
        wait_valid("br_wait");
        chk("br_pc", {32'd0, PC}, 64'h104);
        chk("br_instr", {32'd0, Instruction}, 64'h100);
        repeat (3) cyc();

        // Back-to-back branches while frozen: only the last target is fetched
        freeze = 1'b1;
        repeat (6) cyc();
        branch_taken = 1'b1;
        branch_address = 32'h200;
        cyc();
        branch_address = 32'h300;
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("bb_bubble", {63'd0, valid}, 64'd0);
        wait_valid("bb_wait");
        chk("bb_pc", {32'd0, PC}, 64'h304);
        chk("bb_instr", {32'd0, Instruction}, 64'h300);
        repeat (4) cyc();
        chk("bb_hold_pc", {32'd0, PC}, 64'h304);
        freeze = 1'b0;
        repeat (4) cyc();

        // Address wrap-around
        branch_taken = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("wrap_addr0", {32'd0, imem_addr}, 64'hFFFF_FFFC);
        cyc();
        chk("wrap_addr1", {32'd0, imem_addr}, 64'h0);
        wait_valid("wrap_wait");
        chk("wrap_pc0", {32'd0, PC}, 64'h0);
        chk("wrap_instr0", {32'd0, Instruction}, 64'hFFFF_FFFC);
        cyc();
        chk("wrap_pc1", {32'd0, PC}, 64'h4);
        chk("wrap_instr1", {32'd0, Instruction}, 64'h0);

        // Mid-run reset with entries queued and a request in flight
        freeze = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("mrst_valid", {63'd0, valid}, 64'd0);
        chk("mrst_pc", {32'd0, PC}, 64'd0);
        chk("mrst_instr", {32'd0, Instruction}, 64'd0);
        chk("mrst_count", {61'd0, fifo_count}, 64'd0);
        chk("mrst_req", {63'd0, imem_req}, 64'd0);
        chk("mrst_addr", {32'd0, imem_addr}, 64'd0);
        rst = 1'b0;
        freeze = 1'b0;
        #1;
        chk("mrst_restart", {63'd0, imem_req}, 64'd1);
        wait_valid("mrst_wait");
        chk("mrst_pc1", {32'd0, PC}, 64'h4);
        chk("mrst_instr1", {32'd0, Instruction}, 64'h0);
        repeat (6) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
